div_gen: RTL and testbench

DIV_GEN -- requirements
Module: div_gen

---
 rtl/div_gen.sv | 195 +++++++++++++++++++
 tb/tb_div_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/div_gen.sv
// -----------------------------------------------------------------------------
// div_gen -- iterative signed/unsigned integer divider (restoring algorithm).
//
// Produces one quotient bit per cycle, MSB first. A one-cycle fast path
// handles divide-by-zero and, when EARLY_OUT=1, dividends whose magnitude is
// smaller than the divisor's. All outputs are registered.
//
// Parameters
//   WIDTH      operand width in bits (8..64)
//   EARLY_OUT  1 enables the |dividend| < |divisor| fast path
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous, active-high reset
//   signed_div_i  1 = two's complement division, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       operation request, held high until ready_o is seen
//   annul_i       cancels an in-flight operation
//   result_o      {remainder, quotient}
//   ready_o       result_o is valid
//   busy_o        an operation is in progress (FAST or ON)
//   dbz_o         divide-by-zero flag, valid while ready_o is high
// -----------------------------------------------------------------------------
module div_gen #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               dbz_o
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    FAST,
    ON,
    END
  } state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [WIDTH-1:0]     rem_q;      // partial remainder (top bit is always 0 after a step)
  logic [WIDTH-1:0]     quo_q;      // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     div_q;      // divisor magnitude
  logic                 neg_quo_q;  // operand signs differ
  logic                 neg_rem_q;  // dividend was negative
  logic [2*WIDTH-1:0]   res_q;      // finished result, published in END
  logic                 dbz_int_q;
  logic [2*WIDTH-1:0]   result_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 dbz_q;

  // Combinational helpers
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // NOTE: every variable gets a value on every path through always_comb;
  // a missing assignment would infer a latch.
  always_comb begin
    // Negating the most-negative value yields 2^(WIDTH-1), which is the
    // correct magnitude when read as unsigned.
    mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // One restoring step on a (WIDTH+1)-bit partial remainder: a negative
    // trial difference (bit WIDTH set) means the divisor did not fit.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
    if (trial[WIDTH]) begin
      rem_d = shifted[WIDTH-1:0];
    end else begin
      rem_d = trial[WIDTH-1:0];
    end
    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};

    // Sign fix-up: quotient negative when signs differ, remainder follows
    // the dividend.
    quo_fix = neg_quo_q ? -quo_q : quo_q;
    rem_fix = neg_rem_q ? -rem_q : rem_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_q     <= '0;
      dbz_int_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i && !annul_i) begin
            neg_quo_q <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            neg_rem_q <= signed_div_i && opdata1_i[WIDTH-1];
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (opdata2_i == '0) begin
              state_q   <= FAST;
              res_q     <= '0;
              dbz_int_q <= 1'b1;
            end else if (EARLY_OUT && (mag1 < mag2)) begin
              // Quotient is 0 and the remainder is the dividend unchanged,
              // which already carries the dividend's sign.
              state_q   <= FAST;
              res_q     <= {opdata1_i, {WIDTH{1'b0}}};
              dbz_int_q <= 1'b0;
            end else begin
              state_q   <= ON;
              rem_q     <= '0;
              quo_q     <= mag1;
              div_q     <= mag2;
              dbz_int_q <= 1'b0;
            end
          end
        end

        FAST: begin
          busy_q <= 1'b0;
          if (annul_i) begin
            state_q <= IDLE;
          end else begin
            state_q <= END;
          end
        end

        ON: begin
          if (annul_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q != LAST_CNT) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            // All WIDTH bits are in; this extra cycle applies the sign fix-up.
            res_q   <= {rem_fix, quo_fix};
            state_q <= END;
            busy_q  <= 1'b0;
          end
        end

        END: begin
          // annul_i is deliberately ignored once the result is complete.
          if (!start_i) begin
            state_q  <= IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
          end else begin
            ready_q  <= 1'b1;
            result_q <= res_q;
            dbz_q    <= dbz_int_q;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = busy_q;
  assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_div_gen.sv
// -----------------------------------------------------------------------------
// tb_div_gen -- directed bench for div_gen.
// A 32-bit instance runs a table of {operands, expected result, latency}
// records; hand-written sequences cover annul, reset mid-operation, blocked
// start, and an 8-bit instance regression.
// -----------------------------------------------------------------------------
module tb_div_gen;

  logic        clk = 1'b0;
  logic        rst;

  logic        sgn_i, start_i, annul_i;
  logic [31:0] a_i, b_i;
  logic [63:0] result_o;
  logic        ready_o, busy_o, dbz_o;

  logic        sgn8_i, start8_i, annul8_i;
  logic [7:0]  a8_i, b8_i;
  logic [15:0] result8_o;
  logic        ready8_o, busy8_o, dbz8_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_gen #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .signed_div_i(sgn_i),
    .opdata1_i(a_i), .opdata2_i(b_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .busy_o(busy_o), .dbz_o(dbz_o)
  );

  div_gen #(.WIDTH(8), .EARLY_OUT(1'b1)) dut8 (
    .clk(clk), .rst(rst), .signed_div_i(sgn8_i),
    .opdata1_i(a8_i), .opdata2_i(b8_i),
    .start_i(start8_i), .annul_i(annul8_i),
    .result_o(result8_o), .ready_o(ready8_o), .busy_o(busy8_o), .dbz_o(dbz8_o)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the 32-bit DUT idle; returns at a negedge idle.
  task automatic do_op(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                       input logic dbz, input int lat);
    int edges, busy_cnt;
    bit got;
    sgn_i = sgn; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk);  // start edge
    edges = 0; busy_cnt = 0; got = 1'b0;
    while (!got && edges < 100) begin
      @(negedge clk);
      if (edges == 0) begin
        // Operand changes after the start edge must not matter.
        a_i = ~a; b_i = b + 32'd7; sgn_i = ~sgn;
      end
      if (busy_o) busy_cnt++;
      if (ready_o) got = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " result"}, result_o, {r, q});
    check({tag, " dbz"}, 64'(dbz_o), 64'(dbz));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(lat - 1));
    // Holding start in END keeps the result; annul there is ignored.
    annul_i = 1'b1;
    @(posedge clk); @(negedge clk);
    check({tag, " end hold"}, {62'(0), ready_o, dbz_o} ^ result_o,
          {62'(0), 1'b1, dbz} ^ {r, q});
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, " release"}, {result_o[63:3], ready_o, busy_o, dbz_o} | result_o,
          64'd0);
  endtask

  task automatic do_op8(input string tag, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp, input int lat);
    int edges;
    bit got;
    sgn8_i = sgn; a8_i = a; b8_i = b; start8_i = 1'b1;
    @(posedge clk);
    edges = 0; got = 1'b0;
    while (!got && edges < 40) begin
      @(negedge clk);
      if (ready8_o) got = 1'b1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " result"}, 64'(result8_o), 64'(exp));
    start8_i = 1'b0;
    @(posedge clk); @(negedge clk);
  endtask

  // Runs n cycles from a negedge and reports whether ready_o was ever seen.
  task automatic watch_ready(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ready_o) seen++;
    end
  endtask

  initial begin
    int seen;
    int busy_seen;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34};
    vecs[2]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0,          1'b1, 2};
    vecs[3]  = '{1'b0, 32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 2};
    vecs[4]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34};
    vecs[6]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'd0,          32'hFFFFFFFD,   1'b0, 2};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 34};
    vecs[9]  = '{1'b1, 32'hFFFFFF9C,   32'd0,          32'd0,          32'd0,          1'b1, 2};
    vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 2};
    vecs[11] = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   32'd2,          32'hFFFFFFFE,   1'b0, 34};
    vecs[12] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 2};
    vecs[13] = '{1'b0, 32'd1000,       32'd3,          32'd333,        32'd1,          1'b0, 34};
    vecs[14] = '{1'b1, 32'hFFFFFFFB,   32'd5,          32'hFFFFFFFF,   32'd0,          1'b0, 34};

    rst = 1'b1;
    sgn_i = 1'b0; start_i = 1'b0; annul_i = 1'b0; a_i = '0; b_i = '0;
    sgn8_i = 1'b0; start8_i = 1'b0; annul8_i = 1'b0; a8_i = '0; b8_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {result_o[63:3], ready_o, busy_o, dbz_o} | result_o, 64'd0);
    check("reset outputs w8", {45'(0), ready8_o, busy8_o, dbz8_o} | 64'(result8_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table of vectors, applied back to back with a single idle gap.
    for (int i = 0; i < 15; i++) begin
      do_op($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
            vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
    end

    // annul in IDLE blocks the start.
    a_i = 32'd100; b_i = 32'd7; sgn_i = 1'b0; start_i = 1'b1; annul_i = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy_o || ready_o) busy_seen++;
    end
    check("annul idle blocks", 64'(busy_seen), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;
    @(negedge clk);

    // annul in ON cycle 10 of 1000/3.
    a_i = 32'd1000; b_i = 32'd3; sgn_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("annul busy before", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("annul outputs", {result_o[63:3], ready_o, busy_o, dbz_o} | result_o, 64'd0);
    annul_i = 1'b0;
    watch_ready(40, seen);
    check("annul no ready", 64'(seen), 64'd0);
    do_op("after annul 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // Reset in ON cycle 20.
    a_i = 32'd100; b_i = 32'd7; sgn_i = 1'b0; start_i = 1'b1;
    @(posedge clk);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("reset in ON", {result_o[63:3], ready_o, busy_o, dbz_o} | result_o, 64'd0);
    rst = 1'b0;
    watch_ready(40, seen);
    check("reset no ready", 64'(seen), 64'd0);
    do_op("after reset 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

    // 8-bit regression.
    do_op8("w8 200/7", 1'b0, 8'd200, 8'd7, {8'd4, 8'd28}, 10);
    do_op8("w8 -128/-1", 1'b1, 8'h80, 8'hFF, {8'h00, 8'h80}, 10);
    do_op8("w8 9/0", 1'b0, 8'd9, 8'd0, 16'h0000, 2);
    check("w8 dbz", 64'(dbz8_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
